imem_loadable: RTL and testbench

Parametrised, loadable instruction memory for the pipelined RISC-V core; successor to the fixed case-table instruction ROM.
- Holds DEPTH 32-bit words mapped from BASE_ADDR, with a registered, stall-aware fetch port in the IF stage.
- Takes its program over a byte-serial loader port (little-endian assembly), so programs change without re-synthesis.
- Flags misaligned, out-of-range and not-yet-loaded fetches with a cause code instead of silently returning a pattern.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_loader.sv | 118 +++++++++++
 rtl/imem_loadable.sv | 101 ++++++++++
 tb/tb_imem_loadable.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    MISALIGN = 2'b01,
    RANGE    = 2'b10,
    UNLOADED = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    COMMIT = 2'b10
  } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program loader: assembles little-endian words and emits a
// write strobe into the instruction array. words_loaded is the word pointer.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_byte,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       ld_busy,
  output logic                       ld_overflow,
  output logic [$clog2(DEPTH):0]     words_loaded,
  output logic [$clog2(DEPTH):0]     wl_d_o,     // words_loaded after this edge
  output logic                       busy_d_o,   // ld_busy after this edge
  output logic                       we_o,
  output logic [$clog2(DEPTH)-1:0]   waddr_o,
  output logic [31:0]                wdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  ld_state_e   state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [23:0] asm_q, asm_d;     // bytes 0..2 of the word being assembled
  logic        pend_q, pend_d;   // partial word waiting for COMMIT
  logic        ovf_q, ovf_d;

  // Loader state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      asm_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, byte assembly and write strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    asm_d   = asm_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    we_o    = 1'b0;
    wdata_o = '0;
    waddr_o = ptr_q[AW-1:0];
    case (state_q)
      IDLE: begin
        // A byte presented alongside ld_start is deliberately ignored.
        if (ld_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          ptr_d   = '0;
          asm_d   = '0;
          pend_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          if (ptr_q == DEPTH_W) begin
            ovf_d = 1'b1;                 // array full: drop the byte
          end else if (cnt_q == 2'd3) begin
            we_o    = 1'b1;
            wdata_o = {ld_byte, asm_q};
            ptr_d   = ptr_q + (AW+1)'(1);
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            // Start of a word clears stale bytes so a short tail pads with zeros.
            if (cnt_q == 2'd0) asm_d = '0;
            asm_d[{cnt_q, 3'b000} +: 8] = ld_byte;
            cnt_d  = cnt_q + 2'd1;
            pend_d = 1'b1;
          end
          if (ld_last) state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (pend_q) begin
          we_o    = 1'b1;
          wdata_o = {8'h00, asm_q};
          ptr_d   = ptr_q + (AW+1)'(1);
          pend_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_ready     = (state_q == LOAD);
  assign ld_busy      = (state_q != IDLE);
  assign ld_overflow  = ovf_q;
  assign words_loaded = ptr_q;
  assign wl_d_o       = ptr_d;
  assign busy_d_o     = (state_d != IDLE);

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: array, fetch decode with fault cause, and
// a stall-aware registered fetch port.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter logic [31:0] FILL      = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_en,
  input  logic [31:0]            A,
  output logic [31:0]            RD,
  output logic                   rd_valid,
  output logic [1:0]             fault,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_byte,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_busy,
  output logic                   ld_overflow,
  output logic [$clog2(DEPTH):0] words_loaded
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wl_d;
  logic          busy_d;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  imem_loader #(.DEPTH(DEPTH)) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .ld_busy      (ld_busy),
    .ld_overflow  (ld_overflow),
    .words_loaded (words_loaded),
    .wl_d_o       (wl_d),
    .busy_d_o     (busy_d),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata)
  );

  logic [31:0] mem [DEPTH];

  // Program array; contents are not reset, validity lives in words_loaded
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [29:0]   widx;
  logic [AW-1:0] idx;
  fault_e        fault_d, fault_q;
  logic [31:0]   rd_d, rd_q;
  logic          vld_q;

  // Address decode and fault cause. Validity and data reflect the table as
  // it stands after this edge, so the fetch sampled on the edge leaving
  // COMMIT already sees the committed tail word.
  always_comb begin
    widx    = 30'((A - BASE_ADDR) >> 2);
    idx     = widx[AW-1:0];
    fault_d = NONE;
    if (A[1:0] != 2'b00)                                fault_d = MISALIGN;
    else if (A < BASE_ADDR || widx >= 30'(DEPTH))        fault_d = RANGE;
    else if (widx >= 30'(wl_d))                          fault_d = UNLOADED;
    rd_d = FILL;
    if (fault_d == NONE) rd_d = (we && waddr == idx) ? wdata : mem[idx];
  end

  // Fetch register: blanked while a load is running, held on IF stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= NOP;
      vld_q   <= 1'b0;
      fault_q <= NONE;
    end else if (busy_d) begin
      rd_q    <= NOP;
      vld_q   <= 1'b0;
      fault_q <= NONE;
    end else if (if_en) begin
      rd_q    <= rd_d;
      vld_q   <= 1'b1;
      fault_q <= fault_d;
    end
  end

  assign RD       = rd_q;
  assign rd_valid = vld_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench: fetch stimulus pushes hand-computed expectations, a
// monitor pops them as fetch results appear.
module tb_imem_loadable;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h00400000;
  localparam logic [31:0] FILL  = 32'hDEADBEEF;
  localparam logic [31:0] NOPV  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_en = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] RD;
  logic        rd_valid;
  logic [1:0]  fault;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_ready, ld_busy, ld_overflow;
  logic [3:0]  words_loaded;

  imem_loadable #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .if_en(if_en), .A(A), .RD(RD),
    .rd_valid(rd_valid), .fault(fault), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_overflow(ld_overflow),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  f;
    string       name;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] img[$];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a fetch issued at an edge must show up right after it
  always @(posedge clk) begin
    automatic logic fe = if_en && rst_n;
    exp_t e;
    #1;
    if (fe) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_fetch", 1, 0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_valid"}, rd_valid, 1'b1);
        chk({e.name, "_rd"},    RD,       e.rd);
        chk({e.name, "_fault"}, fault,    e.f);
      end
    end
  end

  task automatic fetch(input string name, input logic [31:0] a,
                       input logic [31:0] rd, input logic [1:0] f);
    exp_t e;
    @(negedge clk);
    A = a;
    if_en = 1'b1;
    e.rd = rd; e.f = f; e.name = name;
    sb.push_back(e);
  endtask

  task automatic stall();
    @(negedge clk);
    if_en = 1'b0;
  endtask

  // Stream img[] as one program image, then wait for the load to finish
  task automatic load(input string name);
    @(negedge clk);
    if_en = 1'b0;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < img.size(); i++) begin
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = (i == img.size() - 1);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int i = 0; i < 10 && ld_busy; i++) @(negedge clk);
    chk({name, "_done"}, ld_busy, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_RD",    RD,           NOPV);
    chk("rst_valid", rd_valid,     1'b0);
    chk("rst_fault", fault,        2'b00);
    chk("rst_ready", ld_ready,     1'b0);
    chk("rst_busy",  ld_busy,      1'b0);
    chk("rst_ovf",   ld_overflow,  1'b0);
    chk("rst_wl",    words_loaded, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fetch("empty", BASE, FILL, 2'b11);
    stall();

    img = '{8'h13, 8'h04, 8'h60, 8'h00, 8'h93, 8'h04, 8'h40, 8'h00};
    load("ld1");
    chk("ld1_wl", words_loaded, 4'd2);
    fetch("ld1_w0", BASE,     32'h00600413, 2'b00);
    fetch("ld1_w1", BASE + 4, 32'h00400493, 2'b00);
    fetch("ld1_w2", BASE + 8, FILL,         2'b11);
    stall();

    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAB};
    load("ld2");
    chk("ld2_wl", words_loaded, 4'd2);
    fetch("ld2_w0", BASE,     32'h04030201, 2'b00);
    fetch("ld2_w1", BASE + 4, 32'h000000AB, 2'b00);

    fetch("misalign",  BASE + 2,         FILL, 2'b01);
    fetch("below",     32'h003FFFFC,     FILL, 2'b10);
    fetch("above",     BASE + 4 * DEPTH, FILL, 2'b10);
    fetch("mis_prio",  32'h00000001,     FILL, 2'b01);

    // Stall: outputs hold while A wanders
    fetch("pre_stall", BASE, 32'h04030201, 2'b00);
    for (int i = 0; i < 3; i++) begin
      stall();
      A = BASE + 4 * (i + 1);
      @(posedge clk); #1;
      chk("stall_rd",    RD,       32'h04030201);
      chk("stall_fault", fault,    2'b00);
      chk("stall_valid", rd_valid, 1'b1);
    end
    fetch("resume", BASE + 4, 32'h000000AB, 2'b00);
    stall();

    // Overflow: DEPTH*4+2 bytes, byte value = its index
    img.delete();
    for (int i = 0; i < DEPTH * 4 + 2; i++) img.push_back(8'(i));
    load("ld3");
    chk("ld3_ovf", ld_overflow,  1'b1);
    chk("ld3_wl",  words_loaded, 4'd8);
    fetch("ld3_w7", BASE + 28, 32'h1F1E1D1C, 2'b00);
    fetch("ld3_w1", BASE + 4,  32'h07060504, 2'b00);
    stall();

    // Restart clears overflow; reset mid-load aborts it
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk("rl_ovf",  ld_overflow,  1'b0);
    chk("rl_wl",   words_loaded, 4'd0);
    chk("rl_busy", ld_busy,      1'b1);
    chk("rl_rd",   RD,           NOPV);
    chk("rl_vld",  rd_valid,     1'b0);
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    rst_n = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("rr_wl",   words_loaded, 4'd0);
    chk("rr_busy", ld_busy,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch("post_rst", BASE, FILL, 2'b11);
    stall();

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
